mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Sequences multi-cycle data-memory accesses for the MEM stage of the pipeline.
- Converts the single-cycle memory read/write intent from the EX/MEM register into a request/ready handshake with an external data memory.
- Freezes the upstream pipeline while an access is in flight and supplies the enable and read data for the MEM/WB register.
- Bounds every access with a timeout so the pipeline can never hang.

Parameters:
- Width, 32, data and address width.
- Timeout, 16, maximum cycles spent in ACCESS before the access is forced to complete (range 1..255).
- StallCntWidth, 16, width of the saturating stall-cycle counter.

Ports:
- clk  input  1  pipeline clock.
- rst  input  1  asynchronous active-high reset.
- mem_read_en  input  1  MEM-stage instruction is a load.
- mem_write_en  input  1  MEM-stage instruction is a store.
- alu_res  input  Width  effective address from the EX/MEM register.
- store_data  input  Width  store operand from the EX/MEM register.
- dmem_req  output  1  request to data memory.
- dmem_we  output  1  1 = write, 0 = read; valid while dmem_req=1.
- dmem_addr  output  Width  latched address.
- dmem_wdata  output  Width  latched store data.
- dmem_rdata  input  Width  read data; sampled when dmem_ready=1.
- dmem_ready  input  1  memory completes the current access.
- freeze  output  1  hold PC, IF/ID, ID/EX and EX/MEM registers.
- memwb_en  output  1  enable for the MEM/WB register.
- data_memory_out  output  Width  load data for the MEM/WB register.
- access_err  output  1  sticky flag: an access timed out.
- stall_cycles  output  StallCntWidth  saturating count of cycles with freeze=1.

Behaviour:
- Reset values:
  - state = IDLE.
  - dmem_req, dmem_we, access_err = 0.
  - dmem_addr, dmem_wdata, data_memory_out, stall_cycles = 0.
  - Internal timeout counter = 0.
  - Reset is asynchronous; a reset mid-access drops dmem_req immediately and abandons the transaction.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - No request: freeze=0, memwb_en=1, data_memory_out holds its value.
  - mem_read_en or mem_write_en high: freeze=1 and memwb_en=0, both combinational in the same cycle.
  - At the clock edge: latch dmem_addr=alu_res and dmem_wdata=store_data; set dmem_we=mem_write_en; clear the timeout counter; go to ACCESS.
- Read and write both high in the same cycle: the write takes precedence and is performed as a store (dmem_we=1).
- ACCESS:
  - dmem_req=1 (registered), freeze=1, memwb_en=0.
  - Address, data and we are stable for the whole state.
  - dmem_ready=1: capture data_memory_out = dmem_rdata on reads only; writes leave it unchanged. Drop dmem_req and go to DONE.
  - dmem_ready=0: increment the timeout counter. When it reaches Timeout-1 with no ready, go to DONE, set access_err=1, and set data_memory_out=0 on reads.
  - dmem_ready asserted on the final timeout cycle counts as success (ready wins); access_err is unchanged.
- DONE:
  - freeze=0, memwb_en=1, dmem_req=0.
  - The frozen instruction advances into MEM/WB this cycle.
  - Unconditionally return to IDLE. DONE never re-triggers on the still-visible request inputs.
- Latency:
  - An access whose ready arrives on the k-th ACCESS cycle (k ≥ 1) produces 1+k freeze cycles.
  - The instruction enters MEM/WB at the edge ending DONE.
- Back-to-back memory instructions: the next instruction is seen in the cycle after DONE (IDLE), so a fresh access starts there with no lost cycle beyond DONE.
- stall_cycles:
  - Increments on every cycle with freeze=1.
  - Saturates at all-ones.
  - Cleared only by rst.
- access_err: sticky until rst.
- dmem_ready outside ACCESS is ignored.

Decomposition:
- Shared pipeline package holds:
  - the state enum (IDLE, ACCESS, DONE);
  - the default Timeout constant;
  - the stall-counter width constant.
- One natural sub-module: sat_counter (parameterised width, inc/clr, saturating), reused for stall_cycles and the timeout counter.

Test Plan:
- Reset, then idle 5 cycles with no request → freeze=0, memwb_en=1, dmem_req=0, stall_cycles=0.
- Load, alu_res=0x100, dmem_ready on the 3rd ACCESS cycle with rdata=0xDEADBEEF → freeze high 4 cycles; data_memory_out=0xDEADBEEF at DONE; memwb_en=1 only in DONE; stall_cycles=4.
- Store, alu_res=0x40, store_data=0x12345678, ready on the 1st ACCESS cycle → dmem_we=1, dmem_addr=0x40, dmem_wdata=0x12345678; 2 freeze cycles; data_memory_out unchanged.
- Load, ready never asserted, Timeout=16 → DONE after 16 ACCESS cycles; access_err=1; data_memory_out=0; a following load with ready completes normally and access_err stays 1.
- Read and write both high, then two back-to-back loads → first access runs with dmem_we=1; the second access starts in the IDLE cycle right after DONE; no duplicate access for the same instruction.
- rst asserted mid-ACCESS → dmem_req and freeze fall asynchronously, all outputs return to reset values, and the next request proceeds normally.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage data-memory access controller.
//   state_e          : access sequencer states
//   TIMEOUT_DEFAULT  : default max cycles spent waiting in ACCESS
//   STALL_CNT_WIDTH  : default width of the stall-cycle counter
//   TMO_CNT_WIDTH    : width of the timeout counter (covers Timeout up to 255)
package mem_access_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam int unsigned TIMEOUT_DEFAULT = 16;
    localparam int unsigned STALL_CNT_WIDTH = 16;
    localparam int unsigned TMO_CNT_WIDTH   = 8;

endpackage

// File: rtl/mem_access_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk_i  : clock
//   rst_i  : asynchronous active-high reset (count -> 0)
//   clr_i  : synchronous clear, wins over inc_i
//   inc_i  : increment by one unless already all-ones
//   cnt_o  : current count
module mem_access_ctrl_sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access sequencer.
// Turns the single-cycle load/store intent from EX/MEM into a req/ready
// handshake, freezes the upstream pipeline while the access is in flight,
// and bounds every access with a timeout.
//
// state  | meaning
// IDLE   | no access in flight; a load/store request freezes combinationally
// ACCESS | dmem_req high, waiting for ready or timeout
// DONE   | access finished; frozen instruction moves into MEM/WB
//
// Ports:
//   clk_i, rst_i              : clock, async active-high reset
//   mem_read_en_i/write_en_i  : MEM-stage load / store intent
//   alu_res_i, store_data_i   : address and store operand from EX/MEM
//   dmem_req_o/we_o/addr_o/wdata_o : request to data memory
//   dmem_rdata_i, dmem_ready_i: response from data memory
//   freeze_o                  : hold PC, IF/ID, ID/EX, EX/MEM
//   memwb_en_o                : MEM/WB register enable
//   data_memory_out_o         : load data for MEM/WB
//   access_err_o              : sticky timeout flag
//   stall_cycles_o            : saturating count of frozen cycles
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned Width         = 32,
    parameter int unsigned Timeout       = TIMEOUT_DEFAULT,
    parameter int unsigned StallCntWidth = STALL_CNT_WIDTH
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     mem_read_en_i,
    input  logic                     mem_write_en_i,
    input  logic [Width-1:0]         alu_res_i,
    input  logic [Width-1:0]         store_data_i,
    output logic                     dmem_req_o,
    output logic                     dmem_we_o,
    output logic [Width-1:0]         dmem_addr_o,
    output logic [Width-1:0]         dmem_wdata_o,
    input  logic [Width-1:0]         dmem_rdata_i,
    input  logic                     dmem_ready_i,
    output logic                     freeze_o,
    output logic                     memwb_en_o,
    output logic [Width-1:0]         data_memory_out_o,
    output logic                     access_err_o,
    output logic [StallCntWidth-1:0] stall_cycles_o
);

    localparam logic [TMO_CNT_WIDTH-1:0] TMO_LAST = TMO_CNT_WIDTH'(Timeout - 1);

    state_e             state_q, state_d;
    logic               we_q, we_d;
    logic [Width-1:0]   addr_q, addr_d;
    logic [Width-1:0]   wdata_q, wdata_d;
    logic [Width-1:0]   rdata_q, rdata_d;
    logic               err_q, err_d;

    logic                     req_seen;
    logic                     tmo_clr;
    logic                     tmo_inc;
    logic                     tmo_hit;
    logic [TMO_CNT_WIDTH-1:0] tmo_cnt;

    // Gate with rst so freeze drops asynchronously even if EX/MEM still
    // presents a memory instruction during reset.
    assign req_seen = ~rst_i & (mem_read_en_i | mem_write_en_i);

    assign tmo_clr = (state_q == IDLE) & req_seen;
    assign tmo_inc = (state_q == ACCESS) & ~dmem_ready_i;
    assign tmo_hit = tmo_inc & (tmo_cnt == TMO_LAST);

    mem_access_ctrl_sat_counter #(.W(TMO_CNT_WIDTH)) u_tmo_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (tmo_clr),
        .inc_i (tmo_inc),
        .cnt_o (tmo_cnt)
    );

    mem_access_ctrl_sat_counter #(.W(StallCntWidth)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (1'b0),
        .inc_i (freeze_o),
        .cnt_o (stall_cycles_o)
    );

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        freeze_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_seen) begin
                    freeze_o = 1'b1;
                    addr_d   = alu_res_i;
                    wdata_d  = store_data_i;
                    // Write wins when both intents are present.
                    we_d     = mem_write_en_i;
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                freeze_o = 1'b1;
                if (dmem_ready_i) begin
                    if (!we_q) rdata_d = dmem_rdata_i;
                    state_d = DONE;
                end else if (tmo_hit) begin
                    err_d = 1'b1;
                    if (!we_q) rdata_d = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign dmem_req_o        = (state_q == ACCESS);
    assign dmem_we_o         = we_q;
    assign dmem_addr_o       = addr_q;
    assign dmem_wdata_o      = wdata_q;
    assign memwb_en_o        = ~freeze_o;
    assign data_memory_out_o = rdata_q;
    assign access_err_o      = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed scoreboard bench for mem_access_ctrl.
module tb_mem_access_ctrl;

    localparam int unsigned W   = 32;
    localparam int unsigned TMO = 16;
    localparam int unsigned SCW = 16;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          mem_read_en_i, mem_write_en_i;
    logic [W-1:0]  alu_res_i, store_data_i;
    logic          dmem_req_o, dmem_we_o;
    logic [W-1:0]  dmem_addr_o, dmem_wdata_o;
    logic [W-1:0]  dmem_rdata_i;
    logic          dmem_ready_i;
    logic          freeze_o, memwb_en_o;
    logic [W-1:0]  data_memory_out_o;
    logic          access_err_o;
    logic [SCW-1:0] stall_cycles_o;

    mem_access_ctrl #(.Width(W), .Timeout(TMO), .StallCntWidth(SCW)) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .mem_read_en_i     (mem_read_en_i),
        .mem_write_en_i    (mem_write_en_i),
        .alu_res_i         (alu_res_i),
        .store_data_i      (store_data_i),
        .dmem_req_o        (dmem_req_o),
        .dmem_we_o         (dmem_we_o),
        .dmem_addr_o       (dmem_addr_o),
        .dmem_wdata_o      (dmem_wdata_o),
        .dmem_rdata_i      (dmem_rdata_i),
        .dmem_ready_i      (dmem_ready_i),
        .freeze_o          (freeze_o),
        .memwb_en_o        (memwb_en_o),
        .data_memory_out_o (data_memory_out_o),
        .access_err_o      (access_err_o),
        .stall_cycles_o    (stall_cycles_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] dout;
        logic        err;
        int          fz;
    } exp_t;

    exp_t        sb[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] dout_m;
    logic        err_m;
    int          stall_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drop_inputs();
        mem_read_en_i  = 1'b0;
        mem_write_en_i = 1'b0;
        alu_res_i      = '0;
        store_data_i   = '0;
    endtask

    // rdy_k = ACCESS cycle on which ready is given; 0 = never (timeout).
    // b2b = called at a DONE negedge: request is presented during DONE.
    task automatic run_access(input bit rd, input bit wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input int rdy_k,
                              input logic [31:0] rdata, input bit b2b);
        exp_t e;
        int   k;
        int   fz;
        bit   done;
        e.we    = wr;
        e.addr  = addr;
        e.wdata = wdata;
        if (rdy_k >= 1 && rdy_k <= int'(TMO)) begin
            if (!wr) dout_m = rdata;
            e.fz = 1 + rdy_k;
        end else begin
            if (!wr) dout_m = '0;
            err_m = 1'b1;
            e.fz  = 1 + int'(TMO);
        end
        e.dout = dout_m;
        e.err  = err_m;
        sb.push_back(e);

        if (!b2b) @(negedge clk_i);
        mem_read_en_i  = rd;
        mem_write_en_i = wr;
        alu_res_i      = addr;
        store_data_i   = wdata;
        if (b2b) begin
            @(negedge clk_i);
            check("no_dup_req", {31'd0, dmem_req_o}, 32'd0);
        end
        #1;
        check("idle_freeze", {31'd0, freeze_o}, 32'd1);
        check("idle_memwb", {31'd0, memwb_en_o}, 32'd0);
        fz   = (freeze_o === 1'b1) ? 1 : 0;
        k    = 0;
        done = 1'b0;
        while (!done && k < 300) begin
            @(negedge clk_i);
            dmem_ready_i = 1'b0;
            if (dmem_req_o !== 1'b1) begin
                done = 1'b1;
            end else begin
                k++;
                if (freeze_o === 1'b1) fz++;
                check("acc_we", {31'd0, dmem_we_o}, {31'd0, e.we});
                check("acc_addr", dmem_addr_o, e.addr);
                check("acc_wdata", dmem_wdata_o, e.wdata);
                check("acc_memwb", {31'd0, memwb_en_o}, 32'd0);
                dmem_ready_i = (k == rdy_k);
                dmem_rdata_i = rdata;
            end
        end
        if (!done) check("access_bound", 32'd0, 32'd1);
        e = sb.pop_front();
        stall_m += e.fz;
        check("freeze_cycles", fz, e.fz);
        check("done_freeze", {31'd0, freeze_o}, 32'd0);
        check("done_memwb", {31'd0, memwb_en_o}, 32'd1);
        check("done_dout", data_memory_out_o, e.dout);
        check("done_err", {31'd0, access_err_o}, {31'd0, e.err});
        check("done_stall", {16'd0, stall_cycles_o}, stall_m);
    endtask

    task automatic idle_after();
        drop_inputs();
        @(negedge clk_i);
        check("post_freeze", {31'd0, freeze_o}, 32'd0);
        check("post_memwb", {31'd0, memwb_en_o}, 32'd1);
        check("post_req", {31'd0, dmem_req_o}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i        = 1'b1;
        dmem_ready_i = 1'b0;
        dmem_rdata_i = '0;
        drop_inputs();
        dout_m  = '0;
        err_m   = 1'b0;
        stall_m = 0;
        repeat (2) @(negedge clk_i);
        check("rst_req", {31'd0, dmem_req_o}, 32'd0);
        check("rst_we", {31'd0, dmem_we_o}, 32'd0);
        check("rst_addr", dmem_addr_o, 32'd0);
        check("rst_wdata", dmem_wdata_o, 32'd0);
        check("rst_dout", data_memory_out_o, 32'd0);
        check("rst_err", {31'd0, access_err_o}, 32'd0);
        check("rst_stall", {16'd0, stall_cycles_o}, 32'd0);
        rst_i = 1'b0;

        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check("idle_freeze0", {31'd0, freeze_o}, 32'd0);
            check("idle_memwb1", {31'd0, memwb_en_o}, 32'd1);
            check("idle_req0", {31'd0, dmem_req_o}, 32'd0);
            check("idle_stall0", {16'd0, stall_cycles_o}, 32'd0);
        end

        run_access(1'b1, 1'b0, 32'h100, 32'h0, 3, 32'hDEADBEEF, 1'b0);
        idle_after();
        run_access(1'b0, 1'b1, 32'h40, 32'h12345678, 1, 32'hFFFF0000, 1'b0);
        idle_after();
        run_access(1'b1, 1'b0, 32'h200, 32'h0, 0, 32'h55555555, 1'b0);
        idle_after();
        run_access(1'b1, 1'b0, 32'h204, 32'h0, 2, 32'hCAFEF00D, 1'b0);
        idle_after();

        run_access(1'b1, 1'b1, 32'h300, 32'hA5A5A5A5, 2, 32'h77777777, 1'b0);
        run_access(1'b1, 1'b0, 32'h304, 32'h0, 1, 32'h11111111, 1'b1);
        run_access(1'b1, 1'b0, 32'h308, 32'h0, 4, 32'h22222222, 1'b1);
        idle_after();

        @(negedge clk_i);
        mem_read_en_i = 1'b1;
        alu_res_i     = 32'h400;
        repeat (2) @(negedge clk_i);
        check("mid_req", {31'd0, dmem_req_o}, 32'd1);
        rst_i = 1'b1;
        #1;
        check("arst_req", {31'd0, dmem_req_o}, 32'd0);
        check("arst_freeze", {31'd0, freeze_o}, 32'd0);
        check("arst_memwb", {31'd0, memwb_en_o}, 32'd1);
        check("arst_err", {31'd0, access_err_o}, 32'd0);
        check("arst_dout", data_memory_out_o, 32'd0);
        check("arst_addr", dmem_addr_o, 32'd0);
        check("arst_stall", {16'd0, stall_cycles_o}, 32'd0);
        dout_m  = '0;
        err_m   = 1'b0;
        stall_m = 0;
        drop_inputs();
        @(negedge clk_i);
        rst_i = 1'b0;
        run_access(1'b1, 1'b0, 32'h500, 32'h0, 2, 32'h33333333, 1'b0);
        idle_after();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
